// File: rtl/nice_outst_tracker.sv
// Multi-outstanding NICE/MMA retire tracker: an in-order tag FIFO checked against
// write-backs, with core memory hold-off, sticky error flags, watchdog and flush.
module nice_outst_tracker #(
    parameter int          MAX_OUTST = 4,
    parameter int          TAG_W     = 3,
    parameter int          TMO_W     = 16,
    parameter int unsigned TMO_LIMIT = 16'hFFFF
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           issue_valid,
    output logic                           issue_ready,
    input  logic [TAG_W-1:0]               issue_tag,
    input  logic                           wb_valid,
    input  logic                           wb_ready,
    input  logic [TAG_W-1:0]               wb_tag,
    output logic                           nice_mem_holdup,
    output logic [$clog2(MAX_OUTST+1)-1:0] outst_cnt,
    output logic                           tag_err,
    output logic                           unf_err,
    output logic                           tmo_err
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);
    localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TMO_LIMIT);

    logic [TAG_W-1:0] fifo [MAX_OUTST];

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;
    logic [TMO_W-1:0] wdog;
    logic [TMO_W-1:0] wdog_next;

    logic iss;
    logic wb;
    logic pop;
    logic underflow;
    logic tag_mismatch;
    logic tmo_hit;
    logic [TAG_W-1:0] head_tag;

    // Pointers wrap at MAX_OUTST-1 so depths that are not powers of two work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign issue_ready  = (count != CNT_MAX);
    assign iss          = issue_valid & issue_ready;
    assign wb           = wb_valid & wb_ready;
    assign pop          = wb & (count != '0);
    assign underflow    = wb & (count == '0);
    assign head_tag     = fifo[rptr];
    assign tag_mismatch = pop & (wb_tag != head_tag);
    assign outst_cnt    = count;

    always_comb begin
        count_next = count;
        if (iss && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (!iss && pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    // Watchdog measures time since the last retirement while work is pending.
    always_comb begin
        wdog_next = wdog;
        tmo_hit   = 1'b0;
        if (count_next == '0 || pop) begin
            wdog_next = '0;
        end else if (count != '0) begin
            if (wdog != TMO_LIM) begin
                wdog_next = wdog + TMO_W'(1);
            end
            tmo_hit = (wdog_next == TMO_LIM);
        end
    end

    // Entries are only read while count says they are valid, so no reset is needed.
    always_ff @(posedge clk) begin
        if (iss && !flush) begin
            fifo[wptr] <= issue_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count           <= '0;
            rptr            <= '0;
            wptr            <= '0;
            wdog            <= '0;
            nice_mem_holdup <= 1'b0;
            tag_err         <= 1'b0;
            unf_err         <= 1'b0;
            tmo_err         <= 1'b0;
        end else if (flush) begin
            count           <= '0;
            rptr            <= '0;
            wptr            <= '0;
            wdog            <= '0;
            nice_mem_holdup <= 1'b0;
            tag_err         <= 1'b0;
            unf_err         <= 1'b0;
            tmo_err         <= 1'b0;
        end else begin
            count           <= count_next;
            wdog            <= wdog_next;
            nice_mem_holdup <= (count_next != '0);
            if (iss) begin
                wptr <= ptr_inc(wptr);
            end
            if (pop) begin
                rptr <= ptr_inc(rptr);
            end
            tag_err <= tag_err | tag_mismatch;
            unf_err <= unf_err | underflow;
            tmo_err <= tmo_err | tmo_hit;
        end
    end

endmodule

// File: tb/tb_nice_outst_tracker.sv
// Directed self-checking bench for nice_outst_tracker (MAX_OUTST=4, TMO_LIMIT=8).
module tb_nice_outst_tracker;

    localparam int MAX_OUTST = 4;
    localparam int TAG_W     = 3;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             issue_valid;
    logic             issue_ready;
    logic [TAG_W-1:0] issue_tag;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic             nice_mem_holdup;
    logic [CNT_W-1:0] outst_cnt;
    logic             tag_err;
    logic             unf_err;
    logic             tmo_err;

    int numChecks = 0;
    int numFails  = 0;

    always #5 clk = ~clk;

    nice_outst_tracker #(
        .MAX_OUTST(MAX_OUTST),
        .TAG_W    (TAG_W),
        .TMO_W    (16),
        .TMO_LIMIT(8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .issue_valid    (issue_valid),
        .issue_ready    (issue_ready),
        .issue_tag      (issue_tag),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_tag         (wb_tag),
        .nice_mem_holdup(nice_mem_holdup),
        .outst_cnt      (outst_cnt),
        .tag_err        (tag_err),
        .unf_err        (unf_err),
        .tmo_err        (tmo_err)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // One clock with the given inputs held; returns #1 after the edge with inputs idle.
    task automatic applyStimulus(input logic iv, input logic [TAG_W-1:0] itag,
                                 input logic wv, input logic wr,
                                 input logic [TAG_W-1:0] wtag, input logic fl);
        issue_valid = iv;
        issue_tag   = itag;
        wb_valid    = wv;
        wb_ready    = wr;
        wb_tag      = wtag;
        flush       = fl;
        @(posedge clk);
        #1;
        issue_valid = 1'b0;
        wb_valid    = 1'b0;
        wb_ready    = 1'b1;
        flush       = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, 1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic doIssue(input logic [TAG_W-1:0] t);
        applyStimulus(1'b1, t, 1'b0, 1'b1, '0, 1'b0);
    endtask

    task automatic doWb(input logic [TAG_W-1:0] t);
        applyStimulus(1'b0, '0, 1'b1, 1'b1, t, 1'b0);
    endtask

    task automatic checkIdleState(input string tag);
        checkOutput({tag, "_cnt"},    int'(outst_cnt), 0);
        checkOutput({tag, "_holdup"}, int'(nice_mem_holdup), 0);
        checkOutput({tag, "_ready"},  int'(issue_ready), 1);
        checkOutput({tag, "_tagerr"}, int'(tag_err), 0);
        checkOutput({tag, "_unferr"}, int'(unf_err), 0);
        checkOutput({tag, "_tmoerr"}, int'(tmo_err), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_tag   = '0;
        wb_valid    = 1'b0;
        wb_ready    = 1'b1;
        wb_tag      = '0;
        #12;
        checkIdleState("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single issue, retire five cycles later
        doIssue(3'd3);
        checkOutput("single_cnt_1", int'(outst_cnt), 1);
        checkOutput("single_holdup_1", int'(nice_mem_holdup), 1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 3'd3, 1'b0);
        checkOutput("single_wb_notready_cnt", int'(outst_cnt), 1);
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("single_holdup_hold", int'(nice_mem_holdup), 1);
        end
        doWb(3'd3);
        checkIdleState("single_done");

        // Fill to MAX_OUTST, held issue with concurrent retire
        for (int i = 0; i < 4; i++) begin
            doIssue(TAG_W'(i));
            checkOutput("fill_cnt", int'(outst_cnt), i + 1);
        end
        checkOutput("full_ready", int'(issue_ready), 0);
        applyStimulus(1'b1, 3'd4, 1'b1, 1'b1, 3'd0, 1'b0);
        checkOutput("full_held_cnt", int'(outst_cnt), 3);
        checkOutput("full_held_ready", int'(issue_ready), 1);
        doIssue(3'd4);
        checkOutput("full_refill_cnt", int'(outst_cnt), 4);
        for (int i = 1; i <= 4; i++) begin
            doWb(TAG_W'(i));
            checkOutput("drain_cnt", int'(outst_cnt), 4 - i);
        end
        checkIdleState("drain_done");

        // Simultaneous issue and retire at count 2
        doIssue(3'd6);
        doIssue(3'd7);
        applyStimulus(1'b1, 3'd5, 1'b1, 1'b1, 3'd6, 1'b0);
        checkOutput("simul_cnt", int'(outst_cnt), 2);
        checkOutput("simul_holdup", int'(nice_mem_holdup), 1);
        doWb(3'd7);
        checkOutput("simul_head7_tagerr", int'(tag_err), 0);
        doWb(3'd5);
        checkIdleState("simul_done");

        // Out-of-order retire and underflow
        doIssue(3'd1);
        doIssue(3'd2);
        doWb(3'd2);
        checkOutput("ooo_tagerr", int'(tag_err), 1);
        checkOutput("ooo_cnt", int'(outst_cnt), 1);
        doWb(3'd2);
        checkOutput("ooo_drain_cnt", int'(outst_cnt), 0);
        doWb(3'd0);
        checkOutput("unf_err", int'(unf_err), 1);
        checkOutput("unf_cnt", int'(outst_cnt), 0);
        checkOutput("unf_tagerr_sticky", int'(tag_err), 1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, '0, 1'b1);
        checkIdleState("flush_errs");

        // Watchdog expiry then flush (flush beats a concurrent issue)
        doIssue(3'd0);
        for (int i = 1; i <= 7; i++) begin
            idle();
            checkOutput("tmo_before", int'(tmo_err), 0);
        end
        idle();
        checkOutput("tmo_expire", int'(tmo_err), 1);
        checkOutput("tmo_cnt", int'(outst_cnt), 1);
        applyStimulus(1'b1, 3'd2, 1'b1, 1'b1, 3'd0, 1'b1);
        checkIdleState("tmo_flush");

        // Asynchronous reset mid-stream
        doIssue(3'd1);
        doIssue(3'd2);
        doIssue(3'd3);
        checkOutput("midrst_cnt_pre", int'(outst_cnt), 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkIdleState("midrst_async");
        rst_n = 1'b1;
        doIssue(3'd0);
        checkOutput("postrst_cnt", int'(outst_cnt), 1);
        checkOutput("postrst_holdup", int'(nice_mem_holdup), 1);
        doWb(3'd0);
        checkIdleState("postrst_done");

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule

// File: doc/nice_outst_tracker.md
Name: nice_outst_tracker

Overview:
- Parametrised multi-outstanding successor of the single-instruction MMA retire tracker.
- Records every NICE/MMA instruction issued to the accelerator in an in-order tag FIFO and checks write-backs against the FIFO head.
- Holds off core memory access (`nice_mem_holdup`) while any instruction is unretired, and back-pressures issue when full.
- Sits between the NICE decode/issue path and the MMA write-back port; adds tag-order checking, write-back underflow detection, watchdog timeout and synchronous flush.

Parameters:
- MAX_OUTST, 4: maximum unretired instructions; any value >= 1, not restricted to powers of two.
- TAG_W, 3: width of the instruction tag carried on issue and write-back.
- TMO_W, 16: width of the watchdog counter.
- TMO_LIMIT, 16'hFFFF: number of cycles with no retirement, while non-empty, that raises the timeout error; must fit in TMO_W bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of all tracking state
- issue_valid  in  1  instruction issue request (calc_start qualifier)
- issue_ready  out  1  tracker can accept an issue
- issue_tag  in  TAG_W  tag of the issuing instruction
- wb_valid  in  1  MMA write-back valid
- wb_ready  in  1  MMA write-back ready
- wb_tag  in  TAG_W  tag of the retiring instruction
- nice_mem_holdup  out  1  registered; high while any instruction is outstanding
- outst_cnt  out  $clog2(MAX_OUTST+1)  current outstanding count
- tag_err  out  1  sticky; a write-back tag mismatched the FIFO head
- unf_err  out  1  sticky; a write-back handshake occurred with the FIFO empty
- tmo_err  out  1  sticky; watchdog expired

Behaviour:
- **Reset** (rst_n low, asynchronous): count=0, read/write pointers=0, watchdog=0; all outputs 0 except issue_ready=1.
- **Handshakes**
  - iss = issue_valid & issue_ready.
  - wb = wb_valid & wb_ready.
  - issue_ready = (count != MAX_OUTST), combinational from registered count only. There is no same-cycle bypass: when full, an issue is refused even if a write-back retires in the same cycle.
- **Push:** on iss, store issue_tag at wptr; wptr wraps from MAX_OUTST-1 to 0.
- **Pop:** on wb with count != 0, compare wb_tag with the entry at rptr.
  - Mismatch: set tag_err. The pop still happens.
  - rptr advances with the same wrap rule.
- **Underflow:** on wb with count == 0, set unf_err. No pop; count stays 0.
- **Count update** (simultaneous events):
  - iss & valid pop: count unchanged.
  - iss only: count+1.
  - valid pop only: count-1.
  - outst_cnt = count register.
- **nice_mem_holdup:** registered; next value = (count_next != 0).
  - Rises the cycle after the first issue.
  - Falls the cycle after the retirement that empties the FIFO.
  - Stays high when the last entry retires and a new issue arrives in the same cycle.
- **Watchdog**
  - Clears to 0 when count_next == 0, or on any valid pop.
  - Otherwise increments while count != 0, saturating at TMO_LIMIT.
  - Reaching TMO_LIMIT sets tmo_err.
- **Sticky errors:** tag_err, unf_err and tmo_err clear only on reset or flush.
- **flush** (synchronous; has priority over iss and wb in the same cycle):
  - count, pointers, watchdog, holdup and all errors go to 0 on the next edge.
  - FIFO contents need no clearing.
- **Reset mid-operation:** all state returns to reset values immediately, regardless of outstanding entries.
- **Error behaviour:** no X propagation into outputs from unwritten FIFO entries. Errors do not block issue or write-back.

Test Plan:
- Single issue tag 3 at cycle 0, write-back tag 3 at cycle 5 -> holdup high cycles 1–5 and low from 6; outst_cnt 1 then 0; no errors.
- Four issues tags 0,1,2,3 back-to-back (MAX_OUTST=4) -> issue_ready low after the 4th; a 5th issue_valid is held off. A write-back of tag 0 concurrent with a held issue still gives no acceptance that cycle; accepted the next cycle; outst_cnt 4→3→4.
- Count 2, same-cycle issue tag 5 and write-back of the head tag -> outst_cnt stays 2, holdup stays 1, FIFO order preserved (next head correct).
- Out-of-order write-back: issue tags 1,2; write-back tag 2 -> tag_err=1 and count=1. Write-back with empty FIFO -> unf_err=1 and count stays 0.
- TMO_LIMIT=8, one issue and no write-back -> tmo_err rises 8 cycles after the issue; flush -> next cycle all errors 0, count 0, holdup 0, issue_ready 1.
- rst_n asserted with count=3 mid-stream -> all outputs at reset values asynchronously; after release, tag 0 issue/retire works from the empty state.
